fft_bitrev_loader: RTL

//  Upstream producer for the FFT ping-pong (PIPO) input buffer. Accepts one frame of
//  2**Log2N samples on a valid/ready stream and writes each sample into the producer

---
 rtl/fft_bitrev_loader.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fft_bitrev_loader.sv
// fft_bitrev_loader
//   Upstream producer for the FFT ping-pong input buffer. It takes one frame of
//   N = 2**Log2N samples from a valid/ready stream and writes each sample into
//   the buffer's producer port at its bit-reversed address, or at its linear
//   address when BitRev=0. When the frame is complete it commits the bank with
//   a one-cycle push.
//   tlast sets the frame length. A short frame is zero-padded up to N. A long
//   frame is cut at N, and its remaining beats are dropped up to tlast.
//
//   Stream handshake: a beat transfers on a rising clk edge where s_tvalid and
//   s_tready are both 1. s_tready depends only on the registered FSM state,
//   never on s_tvalid. While s_tready=0 the producer may hold or change
//   s_tdata and s_tlast.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   s_tdata/s_tvalid/s_tlast/s_tready   input sample stream
//   o_ce0, o_we0, o_address0, o_d0      buffer producer write port
//   o_ce, o_write                       buffer push strobe (one cycle per frame)
//   i_full_n                            buffer has a free bank
//   err_short, err_long                 one-cycle framing error pulses
//   frame_count                         committed frames, wraps at 2**16
module fft_bitrev_loader #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 10,
  parameter int Log2N        = 5,
  parameter int BitRev       = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DataWidth-1:0]    s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic                    o_ce0,
  output logic                    o_we0,
  output logic [AddressWidth-1:0] o_address0,
  output logic [DataWidth-1:0]    o_d0,
  output logic                    o_ce,
  output logic                    o_write,
  input  logic                    i_full_n,
  output logic                    err_short,
  output logic                    err_long,
  output logic [15:0]             frame_count
);

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_FILL   = 3'd1,
    S_PAD    = 3'd2,
    S_COMMIT = 3'd3,
    S_DROP   = 3'd4
  } state_t;

  // idx has one spare bit. It briefly reaches N on the beat that ends the
  // frame, and is cleared in COMMIT.
  typedef logic [Log2N:0]   idx_t;
  typedef logic [Log2N-1:0] ptr_t;

  localparam idx_t LastIdx = idx_t'((1 << Log2N) - 1);

  state_t state;
  idx_t   idx;
  logic   drop_pend;
  ptr_t   rev_idx;
  ptr_t   wr_ptr;

  // Mirror the low Log2N bits of idx. idx bit 0 becomes the address MSB.
  always_comb begin
    rev_idx = '0;
    for (int i = 0; i < Log2N; i++) begin
      rev_idx[i] = idx[Log2N-1-i];
    end
    wr_ptr = (BitRev != 0) ? rev_idx : idx[Log2N-1:0];
  end

  assign s_tready = (state == S_FILL) || (state == S_DROP);
  assign o_ce     = (state == S_COMMIT);
  assign o_write  = (state == S_COMMIT);

  // The write port is combinational. A FILL beat reaches the buffer in the
  // same cycle that it is accepted.
  always_comb begin
    o_ce0      = 1'b0;
    o_we0      = 1'b0;
    o_d0       = '0;
    o_address0 = '0;
    if (state == S_FILL && s_tvalid) begin
      o_ce0                  = 1'b1;
      o_we0                  = 1'b1;
      o_d0                   = s_tdata;
      o_address0[Log2N-1:0]  = wr_ptr;
    end else if (state == S_PAD) begin
      o_ce0                  = 1'b1;
      o_we0                  = 1'b1;
      o_address0[Log2N-1:0]  = wr_ptr;
    end
  end

  // Push safety: a frame starts only when i_full_n=1, and this block is the
  // only pusher. After COMMIT the FSM always passes through WAIT, or through
  // DROP and then WAIT. By that point the buffer's registered i_full_n
  // already reflects the push.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_WAIT;
      idx         <= '0;
      drop_pend   <= 1'b0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
      frame_count <= '0;
    end else begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
      case (state)
        S_WAIT: begin
          if (i_full_n) state <= S_FILL;
        end
        S_FILL: begin
          if (s_tvalid) begin
            idx <= idx + 1'b1;
            if (idx == LastIdx) begin
              state <= S_COMMIT;
              if (!s_tlast) begin
                err_long  <= 1'b1;
                drop_pend <= 1'b1;
              end
            end else if (s_tlast) begin
              err_short <= 1'b1;
              state     <= S_PAD;
            end
          end
        end
        S_PAD: begin
          idx <= idx + 1'b1;
          if (idx == LastIdx) state <= S_COMMIT;
        end
        S_COMMIT: begin
          idx         <= '0;
          frame_count <= frame_count + 16'd1;
          state       <= drop_pend ? S_DROP : S_WAIT;
        end
        S_DROP: begin
          if (s_tvalid && s_tlast) begin
            drop_pend <= 1'b0;
            state     <= S_WAIT;
          end
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule
